// File: rtl/cache_axi_bridge_n.sv
`default_nettype none
// ============================================================================
// Module   : cache_axi_bridge_n
// Purpose  : Bridges NUM_RD cache refill ports and one write-back port onto a
//            single AXI3 master, with line bursts and a read-after-write line
//            hazard mask. Define BRIDGE_RR_ARB_EN for round-robin read grant;
//            otherwise the lowest requesting index wins.
// Revision : 1.0 - initial release
// ============================================================================
module cache_axi_bridge_n #(
    parameter int NUM_RD     = 2,
    parameter int LINE_WORDS = 4,
    parameter int OFF_W      = $clog2(LINE_WORDS) + 2
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    // cache read ports
    input  logic [NUM_RD-1:0]          rd_req,
    input  logic [3*NUM_RD-1:0]        rd_type,
    input  logic [32*NUM_RD-1:0]       rd_addr,
    output logic [NUM_RD-1:0]          rd_rdy,
    output logic [NUM_RD-1:0]          ret_valid,
    output logic [NUM_RD-1:0]          ret_last,
    output logic [31:0]                ret_data,
    // write-back port
    input  logic                       wr_req,
    input  logic [2:0]                 wr_type,
    input  logic [31:0]                wr_addr,
    input  logic [3:0]                 wr_wstrb,
    input  logic [32*LINE_WORDS-1:0]   wr_data,
    output logic                       wr_rdy,
    // AR channel
    output logic [3:0]                 arid,
    output logic [31:0]                araddr,
    output logic [7:0]                 arlen,
    output logic [2:0]                 arsize,
    output logic [1:0]                 arburst,
    output logic [1:0]                 arlock,
    output logic [3:0]                 arcache,
    output logic [2:0]                 arprot,
    output logic                       arvalid,
    input  logic                       arready,
    // R channel
    input  logic [3:0]                 rid,
    input  logic [31:0]                rdata,
    input  logic [1:0]                 rresp,
    input  logic                       rlast,
    input  logic                       rvalid,
    output logic                       rready,
    // AW channel
    output logic [3:0]                 awid,
    output logic [31:0]                awaddr,
    output logic [7:0]                 awlen,
    output logic [2:0]                 awsize,
    output logic [1:0]                 awburst,
    output logic [1:0]                 awlock,
    output logic [3:0]                 awcache,
    output logic [2:0]                 awprot,
    output logic                       awvalid,
    input  logic                       awready,
    // W channel
    output logic [3:0]                 wid,
    output logic [31:0]                wdata,
    output logic [3:0]                 wstrb,
    output logic                       wlast,
    output logic                       wvalid,
    input  logic                       wready,
    // B channel
    input  logic [3:0]                 bid,
    input  logic [1:0]                 bresp,
    input  logic                       bvalid,
    output logic                       bready
);

    localparam int IDX_W  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    localparam logic [7:0]        C_LINE_LEN  = 8'(LINE_WORDS - 1);
    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [2:0]        C_TYPE_LINE = 3'b100;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_AR   = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_AW   = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_B    = 2'd3;

    logic [1:0]                   r_rd_state;
    logic [IDX_W-1:0]             r_rd_idx;
    logic [2:0]                   r_rd_type;
    logic [31:0]                  r_rd_addr;

    logic [1:0]                   r_wr_state;
    logic [2:0]                   r_wbuf_type;
    logic [31:0]                  r_wbuf_addr;
    logic [3:0]                   r_wbuf_strb;
    logic [LINE_WORDS-1:0][31:0]  r_wbuf_data;
    logic [BEAT_W-1:0]            r_beat;

    logic [NUM_RD-1:0]            w_req_ok;
    logic [2:0]                   w_rd_type_arr [NUM_RD];
    logic [31:0]                  w_rd_addr_arr [NUM_RD];
    logic                         w_grant_vld;
    logic [IDX_W-1:0]             w_grant_idx;
    logic                         w_rd_idle;
    logic                         w_rd_line;
    logic                         w_r_beat;
    logic                         w_wr_busy;
    logic                         w_wr_line;
    logic                         w_unused;

    assign w_rd_idle = (r_rd_state == R_IDLE);
    assign w_rd_line = (r_rd_type == C_TYPE_LINE);
    assign w_r_beat  = (r_rd_state == R_DATA) && rvalid;
    assign w_wr_busy = (r_wr_state != W_IDLE);
    assign w_wr_line = (r_wbuf_type == C_TYPE_LINE);
    assign w_unused  = ^{rresp, bresp, bid};

    // A port reading the line currently held in the write buffer must wait
    // until the write is acknowledged, otherwise it could refill stale data.
    generate
        for (genvar i = 0; i < NUM_RD; i++) begin : g_port
            assign w_rd_type_arr[i] = rd_type[3*i +: 3];
            assign w_rd_addr_arr[i] = rd_addr[32*i +: 32];
            assign w_req_ok[i]  = rd_req[i] &&
                                  !(w_wr_busy &&
                                    (w_rd_addr_arr[i][31:OFF_W] == r_wbuf_addr[31:OFF_W]));
            assign rd_rdy[i]    = w_rd_idle && w_grant_vld && (w_grant_idx == IDX_W'(i));
            assign ret_valid[i] = w_r_beat && (rid == 4'(i));
            assign ret_last[i]  = w_r_beat && rlast && (rid == 4'(i));
        end
    endgenerate

`ifdef BRIDGE_RR_ARB_EN
    logic [IDX_W-1:0] r_rr_ptr;

    // Lowest requester overall, then overridden by the lowest one at or
    // above the pointer when such a requester exists.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int i = NUM_RD - 1; i >= 0; i--) begin
            if (w_req_ok[i]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = IDX_W'(i);
            end
        end
        for (int i = NUM_RD - 1; i >= 0; i--) begin
            if (w_req_ok[i] && (IDX_W'(i) >= r_rr_ptr)) begin
                w_grant_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rr_ptr <= '0;
        end else if (w_rd_idle && w_grant_vld) begin
            r_rr_ptr <= (w_grant_idx == IDX_W'(NUM_RD - 1)) ? '0 : w_grant_idx + IDX_W'(1);
        end
    end
`else
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int i = NUM_RD - 1; i >= 0; i--) begin
            if (w_req_ok[i]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = IDX_W'(i);
            end
        end
    end
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_rd_state <= R_IDLE;
            r_rd_idx   <= '0;
            r_rd_type  <= '0;
            r_rd_addr  <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_grant_vld) begin
                        r_rd_idx   <= w_grant_idx;
                        r_rd_type  <= w_rd_type_arr[w_grant_idx];
                        r_rd_addr  <= w_rd_addr_arr[w_grant_idx];
                        r_rd_state <= R_AR;
                    end
                end
                R_AR:    if (arready) r_rd_state <= R_DATA;
                R_DATA:  if (rvalid && rlast) r_rd_state <= R_IDLE;
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    assign arid     = 4'(r_rd_idx);
    assign araddr   = w_rd_line ? {r_rd_addr[31:OFF_W], {OFF_W{1'b0}}} : r_rd_addr;
    assign arlen    = w_rd_line ? C_LINE_LEN : 8'd0;
    assign arsize   = w_rd_line ? 3'd2 : {1'b0, r_rd_type[1:0]};
    assign arburst  = 2'b01;
    assign arlock   = 2'b00;
    assign arcache  = 4'b0000;
    assign arprot   = 3'b000;
    assign arvalid  = (r_rd_state == R_AR);
    assign rready   = (r_rd_state == R_DATA);
    assign ret_data = rdata;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_state  <= W_IDLE;
            r_wbuf_type <= '0;
            r_wbuf_addr <= '0;
            r_wbuf_strb <= '0;
            r_wbuf_data <= '0;
            r_beat      <= '0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (wr_req) begin
                        r_wbuf_type <= wr_type;
                        r_wbuf_addr <= wr_addr;
                        r_wbuf_strb <= wr_wstrb;
                        r_wbuf_data <= wr_data;
                        r_wr_state  <= W_AW;
                    end
                end
                W_AW: if (awready) r_wr_state <= W_DATA;
                W_DATA: begin
                    if (wready) begin
                        if (wlast) begin
                            r_beat     <= '0;
                            r_wr_state <= W_B;
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end
                end
                W_B:     if (bvalid) r_wr_state <= W_IDLE;
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    assign wr_rdy  = (r_wr_state == W_IDLE);
    assign awid    = 4'd1;
    assign awaddr  = w_wr_line ? {r_wbuf_addr[31:OFF_W], {OFF_W{1'b0}}} : r_wbuf_addr;
    assign awlen   = w_wr_line ? C_LINE_LEN : 8'd0;
    assign awsize  = w_wr_line ? 3'd2 : {1'b0, r_wbuf_type[1:0]};
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = (r_wr_state == W_AW);
    assign wid     = 4'd1;
    assign wdata   = r_wbuf_data[r_beat];
    assign wstrb   = w_wr_line ? 4'hF : r_wbuf_strb;
    assign wlast   = w_wr_line ? (r_beat == C_LAST_BEAT) : 1'b1;
    assign wvalid  = (r_wr_state == W_DATA);
    assign bready  = (r_wr_state == W_B);

endmodule
`default_nettype wire

// File: tb/tb_cache_axi_bridge_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_axi_bridge_n
// Purpose  : Directed self-checking bench for cache_axi_bridge_n.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_axi_bridge_n;

    localparam int NUM_RD     = 2;
    localparam int LINE_WORDS = 4;

    logic                      aclk = 1'b0;
    logic                      aresetn;
    logic [NUM_RD-1:0]         rd_req;
    logic [3*NUM_RD-1:0]       rd_type;
    logic [32*NUM_RD-1:0]      rd_addr;
    logic [NUM_RD-1:0]         rd_rdy;
    logic [NUM_RD-1:0]         ret_valid;
    logic [NUM_RD-1:0]         ret_last;
    logic [31:0]               ret_data;
    logic                      wr_req;
    logic [2:0]                wr_type;
    logic [31:0]               wr_addr;
    logic [3:0]                wr_wstrb;
    logic [32*LINE_WORDS-1:0]  wr_data;
    logic                      wr_rdy;
    logic [3:0]                arid;
    logic [31:0]               araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic [1:0]                arlock;
    logic [3:0]                arcache;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [3:0]                rid;
    logic [31:0]               rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;
    logic [3:0]                awid;
    logic [31:0]               awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic [1:0]                awlock;
    logic [3:0]                awcache;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [3:0]                wid;
    logic [31:0]               wdata;
    logic [3:0]                wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;
    logic [3:0]                bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    int n_checks = 0;
    int n_fails  = 0;

    cache_axi_bridge_n #(.NUM_RD(NUM_RD), .LINE_WORDS(LINE_WORDS)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    logic [31:0]       exp_w [4];
    logic [NUM_RD-1:0] exp_rdy;
    logic [3:0]        exp_id;

    initial begin
        exp_w[0] = 32'hAAAA_0001;
        exp_w[1] = 32'hBBBB_0002;
        exp_w[2] = 32'hCCCC_0003;
        exp_w[3] = 32'hDDDD_0004;

        aresetn = 1'b0; rd_req = '0; rd_type = '0; rd_addr = '0;
        wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;

        // ---------------- reset state
        step(); step();
        check_eq("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
        check_eq("rst_wr_rdy", wr_rdy, 1'b1);
        aresetn = 1'b1;
        step();
        check_eq("idle_rd_rdy", rd_rdy, 2'b00);

        // ---------------- single line read on port 0
        rd_req = 2'b01; rd_type[2:0] = 3'b100; rd_addr[31:0] = 32'h1C00_0008;
        #1 check_eq("t1_rd_rdy", rd_rdy, 2'b01);
        step();
        rd_req = 2'b00;
        check_eq("t1_arvalid", arvalid, 1'b1);
        check_eq("t1_araddr", araddr, 32'h1C00_0000);
        check_eq("t1_arlen", arlen, 8'd3);
        check_eq("t1_arid_size_burst", {arid, arsize, arburst}, {4'd0, 3'd2, 2'b01});
        check_eq("t1_ar_attr", {arlock, arcache, arprot}, 9'd0);
        step();
        check_eq("t1_ar_hold", {arvalid, araddr}, {1'b1, 32'h1C00_0000});
        arready = 1'b1;
        step();
        arready = 1'b0;
        check_eq("t1_rready", {rready, arvalid}, 2'b10);
        for (int k = 0; k < 4; k++) begin
            rvalid = 1'b1; rid = 4'd0; rdata = 32'h5A00_0000 + k; rlast = (k == 3);
            #1;
            check_eq("t1_ret_valid", ret_valid, 2'b01);
            check_eq("t1_ret_data", ret_data, 32'h5A00_0000 + k);
            check_eq("t1_ret_last", ret_last, (k == 3) ? 2'b01 : 2'b00);
            step();
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1 check_eq("t1_done", {rready, ret_valid}, 3'b000);

        // ---------------- contention (fresh reset so the pointer starts at 0)
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        rd_req = 2'b11;
        rd_type = {3'b100, 3'b100};
        rd_addr = {32'h0000_0200, 32'h0000_0100};
        for (int g = 0; g < 4; g++) begin
            #1;
`ifdef BRIDGE_RR_ARB_EN
            exp_rdy = (g % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_rdy = 2'b01;
`endif
            exp_id = (exp_rdy == 2'b10) ? 4'd1 : 4'd0;
            check_eq("t2_rd_rdy", rd_rdy, exp_rdy);
            step();
            check_eq("t2_arid", arid, exp_id);
            check_eq("t2_busy_rdy", rd_rdy, 2'b00);
            arready = 1'b1;
            step();
            arready = 1'b0;
            rvalid = 1'b1; rid = exp_id; rdata = 32'hC0DE_0000 + g; rlast = 1'b1;
            #1 check_eq("t2_ret_valid", ret_valid, exp_rdy);
            step();
            rvalid = 1'b0; rlast = 1'b0;
        end
        rd_req = 2'b00;

        // ---------------- line write with hazard on port 1
        wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h0000_1000;
        wr_data = {exp_w[3], exp_w[2], exp_w[1], exp_w[0]};
        #1 check_eq("t3_wr_rdy", wr_rdy, 1'b1);
        step();
        wr_req = 1'b0;
        check_eq("t3_awvalid", {awvalid, wr_rdy}, 2'b10);
        check_eq("t3_awaddr", awaddr, 32'h0000_1000);
        check_eq("t3_awlen_size", {awlen, awsize, awburst, awid}, {8'd3, 3'd2, 2'b01, 4'd1});
        rd_req = 2'b10; rd_type = {3'b100, 3'b100}; rd_addr = {32'h0000_1004, 32'h0000_2000};
        #1 check_eq("t3_haz_aw", rd_rdy, 2'b00);
        awready = 1'b1;
        step();
        awready = 1'b0;
        check_eq("t3_first_w", {awvalid, wvalid, wlast, wid}, {1'b0, 1'b1, 1'b0, 4'd1});
        check_eq("t3_wdata0", wdata, exp_w[0]);
        check_eq("t3_haz_w", rd_rdy, 2'b00);
        rd_req = 2'b11;
        #1 check_eq("t3_other_port", rd_rdy, 2'b01);
        rd_req = 2'b10;
        step();
        check_eq("t3_stall", {wvalid, wdata}, {1'b1, exp_w[0]});
        wready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("t3_wdata", wdata, exp_w[k]);
            check_eq("t3_wlast_strb", {wvalid, wlast, wstrb}, {1'b1, (k == 3), 4'hF});
            step();
        end
        wready = 1'b0;
        #1 check_eq("t3_wb", {wvalid, bready, wr_rdy}, 3'b010);
        check_eq("t3_haz_b", rd_rdy, 2'b00);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        #1 check_eq("t3_wr_rdy_back", {wr_rdy, bready}, 2'b10);
        check_eq("t3_haz_clear", rd_rdy, 2'b10);
        rd_req = 2'b00;

        // ---------------- single store
        wr_req = 1'b1; wr_type = 3'b010; wr_addr = 32'h0000_3004; wr_wstrb = 4'b0011;
        wr_data = '0;
        wr_data[31:0] = 32'h1234_5678;
        step();
        wr_req = 1'b0;
        check_eq("t4_aw", {awvalid, awlen, awsize}, {1'b1, 8'd0, 3'd2});
        check_eq("t4_awaddr", awaddr, 32'h0000_3004);
        awready = 1'b1;
        step();
        awready = 1'b0;
        check_eq("t4_w", {wvalid, wlast, wstrb}, {1'b1, 1'b1, 4'b0011});
        check_eq("t4_wdata", wdata, 32'h1234_5678);
        wready = 1'b1;
        step();
        wready = 1'b0;
        check_eq("t4_b", {wvalid, bready}, 2'b01);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        check_eq("t4_wr_rdy", wr_rdy, 1'b1);

        // ---------------- reset during beat 2 of a read burst
        rd_req = 2'b01; rd_type[2:0] = 3'b100; rd_addr[31:0] = 32'h0000_4000;
        step();
        rd_req = 2'b00;
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_0B01; rlast = 1'b0;
        step();
        rdata = 32'h0000_0B02;
        #1 check_eq("t5_beat2", ret_valid, 2'b01);
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        #1 check_eq("t5_after_rst", {arvalid, rready, ret_valid}, 4'b0000);
        check_eq("t5_wr_rdy", wr_rdy, 1'b1);
        step();
        check_eq("t5_no_ret", {ret_valid, ret_last}, 4'b0000);
        rvalid = 1'b0;
        rd_req = 2'b01;
        #1 check_eq("t5_idle", rd_rdy, 2'b01);
        rd_req = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
